// File: rtl/imem_access_ctrl.sv
// Byte-wide instruction memory access controller: splits 16-bit loader writes and
// CPU fetches into two byte cycles, gives the loader priority, and freezes fetch on HALT_WORD.
module imem_access_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  output logic              ld_ack,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_pc,
  output logic              f_valid,
  output logic [15:0]       f_instr,
  output logic              halted,
  input  logic              halt_clr,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_HI = 3'd1,
    WR_LO = 3'd2,
    RD_HI = 3'd3,
    RD_LO = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_lo;
  logic [15:0]       data_q;
  logic [7:0]        hi_byte;
  logic [15:0]       rd_word;
  logic              req_ok;
  logic              take_ld;
  logic              take_f;

  assign addr_lo = addr_q + ADDR_ONE;
  assign rd_word = {hi_byte, mem_rdata};

  // A request still held during its own ack/valid cycle must not start a second access.
  assign req_ok  = !ld_ack && !f_valid;

  always_comb begin
    state_d = state_q;
    take_ld = 1'b0;
    take_f  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_ok && ld_req) begin
          take_ld = 1'b1;
          state_d = WR_HI;
        end else if (req_ok && f_req) begin
          take_f  = 1'b1;
          state_d = RD_HI;
        end
      end
      WR_HI: state_d = WR_LO;
      // halted is still set for a write started from HALT, so it doubles as the return flag.
      WR_LO: state_d = halted ? HALT : IDLE;
      RD_HI: state_d = RD_LO;
      RD_LO: state_d = (rd_word == HALT_WORD) ? HALT : IDLE;
      HALT: begin
        if (req_ok && ld_req) begin
          take_ld = 1'b1;
          state_d = WR_HI;
        end else if (halt_clr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    unique case (state_q)
      WR_HI: begin
        mem_addr  = addr_q;
        mem_we    = 1'b1;
        mem_wdata = data_q[15:8];
        busy      = 1'b1;
      end
      WR_LO: begin
        mem_addr  = addr_lo;
        mem_we    = 1'b1;
        mem_wdata = data_q[7:0];
        busy      = 1'b1;
      end
      RD_HI: begin
        mem_addr = addr_q;
        busy     = 1'b1;
      end
      RD_LO: begin
        mem_addr = addr_lo;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      hi_byte <= '0;
      f_instr <= '0;
      f_valid <= 1'b0;
      ld_ack  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_valid <= (state_q == RD_LO);
      ld_ack  <= (state_q == WR_LO);
      if (take_ld) begin
        addr_q <= ld_addr;
        data_q <= ld_data;
      end else if (take_f) begin
        addr_q <= f_pc;
      end
      if (state_q == RD_HI) begin
        hi_byte <= mem_rdata;
      end
      if (state_q == RD_LO) begin
        f_instr <= rd_word;
        if (rd_word == HALT_WORD) begin
          halted <= 1'b1;
        end
      end else if (state_q == HALT && state_d == IDLE) begin
        halted <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a 256-byte behavioural memory.
module tb_imem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_req;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_ack;
  logic        f_req;
  logic [7:0]  f_pc;
  logic        f_valid;
  logic [15:0] f_instr;
  logic        halted;
  logic        halt_clr;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [256];
  logic        pk_en;
  logic [7:0]  pk_addr;
  logic [7:0]  pk_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_access_ctrl #(.ADDR_W(8), .HALT_WORD(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .f_req(f_req), .f_pc(f_pc), .f_valid(f_valid), .f_instr(f_instr),
    .halted(halted), .halt_clr(halt_clr), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [15:0] d);
    int n;
    ld_req = 1'b1; ld_addr = a; ld_data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ld_ack && n < 20);
    check({tag, "_ack_lat"}, 32'(n), 3);
    ld_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fetch(input string tag, input logic [7:0] pc, input logic [15:0] exp);
    int n;
    f_req = 1'b1; f_pc = pc;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_valid && n < 20);
    check({tag, "_lat"}, 32'(n), 3);
    check({tag, "_instr"}, 32'(f_instr), 32'(exp));
    f_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, cnt;
    reset_n = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    f_req = 1'b0; f_pc = '0; halt_clr = 1'b0;
    pk_en = 1'b0; pk_addr = '0; pk_data = '0;
    repeat (2) @(negedge clk);
    poke(8'h00, 8'h21);
    poke(8'h01, 8'hFE);
    poke(8'h40, 8'h00);
    poke(8'h41, 8'h00);
    poke(8'h61, 8'h77);

    check("rst_ld_ack", 32'(ld_ack), 0);
    check("rst_f_valid", 32'(f_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_f_instr", 32'(f_instr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // Fetch from 0, cycle by cycle
    f_req = 1'b1; f_pc = 8'h00;
    @(negedge clk);
    check("f1_busy_c1", 32'(busy), 1);
    check("f1_addr_c1", 32'(mem_addr), 32'h00);
    check("f1_valid_c1", 32'(f_valid), 0);
    @(negedge clk);
    check("f1_busy_c2", 32'(busy), 1);
    check("f1_addr_c2", 32'(mem_addr), 32'h01);
    check("f1_valid_c2", 32'(f_valid), 0);
    @(negedge clk);
    check("f1_valid_c3", 32'(f_valid), 1);
    check("f1_instr", 32'(f_instr), 32'h21FE);
    check("f1_busy_c3", 32'(busy), 0);
    f_req = 1'b0;
    @(negedge clk);
    check("f1_valid_pulse", 32'(f_valid), 0);
    check("f1_instr_hold", 32'(f_instr), 32'h21FE);

    // Write BEEF at 0x10, cycle by cycle
    ld_req = 1'b1; ld_addr = 8'h10; ld_data = 16'hBEEF;
    @(negedge clk);
    check("w1_we_hi", 32'(mem_we), 1);
    check("w1_addr_hi", 32'(mem_addr), 32'h10);
    check("w1_wdata_hi", 32'(mem_wdata), 32'hBE);
    check("w1_ack_c1", 32'(ld_ack), 0);
    @(negedge clk);
    check("w1_we_lo", 32'(mem_we), 1);
    check("w1_addr_lo", 32'(mem_addr), 32'h11);
    check("w1_wdata_lo", 32'(mem_wdata), 32'hEF);
    @(negedge clk);
    check("w1_ack", 32'(ld_ack), 1);
    check("w1_we_off", 32'(mem_we), 0);
    check("w1_wdata_off", 32'(mem_wdata), 0);
    ld_req = 1'b0;
    @(negedge clk);
    check("w1_ack_pulse", 32'(ld_ack), 0);
    check("w1_mem10", 32'(mem[8'h10]), 32'hBE);
    check("w1_mem11", 32'(mem[8'h11]), 32'hEF);
    do_fetch("f2", 8'h10, 16'hBEEF);

    // Simultaneous requests: loader first, fetch 4 cycles after ld_ack
    ld_req = 1'b1; ld_addr = 8'h20; ld_data = 16'h5A5A;
    f_req = 1'b1; f_pc = 8'h20;
    n = 0;
    do begin @(negedge clk); n++; end while (!ld_ack && n < 20);
    check("sim_ack_lat", 32'(n), 3);
    check("sim_no_valid_yet", 32'(f_valid), 0);
    ld_req = 1'b0;
    m = 0;
    do begin @(negedge clk); m++; end while (!f_valid && m < 20);
    check("sim_fetch_gap", 32'(m), 4);
    check("sim_instr", 32'(f_instr), 32'h5A5A);
    f_req = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (ld_ack || f_valid) cnt++; end
    check("sim_no_dup", 32'(cnt), 0);

    // Address wrap
    do_write("wrap_w", 8'hFF, 16'h1234);
    check("wrap_memFF", 32'(mem[8'hFF]), 32'h12);
    check("wrap_mem00", 32'(mem[8'h00]), 32'h34);
    do_fetch("wrap_f", 8'hFF, 16'h1234);

    // HALT
    f_req = 1'b1; f_pc = 8'h40;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_valid && n < 20);
    check("halt_lat", 32'(n), 3);
    check("halt_instr", 32'(f_instr), 0);
    check("halt_set", 32'(halted), 1);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (f_valid) cnt++; end
    check("halt_no_fetch", 32'(cnt), 0);
    check("halt_busy", 32'(busy), 0);
    check("halt_held", 32'(halted), 1);
    f_req = 1'b0;
    do_write("halt_w", 8'h50, 16'hABCD);
    check("halt_after_w", 32'(halted), 1);
    check("halt_mem50", 32'(mem[8'h50]), 32'hAB);
    check("halt_mem51", 32'(mem[8'h51]), 32'hCD);
    halt_clr = 1'b1;
    @(negedge clk);
    halt_clr = 1'b0;
    check("halt_cleared", 32'(halted), 0);
    do_fetch("halt_f", 8'h50, 16'hABCD);
    check("halt_still_clear", 32'(halted), 0);

    // Reset in the middle of WR_LO
    ld_req = 1'b1; ld_addr = 8'h60; ld_data = 16'h9876;
    @(negedge clk);
    @(negedge clk);
    check("rst2_in_wrlo", 32'(mem_we), 1);
    #1 reset_n = 1'b0;
    #1;
    check("rst2_mem_we", 32'(mem_we), 0);
    check("rst2_busy", 32'(busy), 0);
    check("rst2_ld_ack", 32'(ld_ack), 0);
    check("rst2_f_valid", 32'(f_valid), 0);
    check("rst2_halted", 32'(halted), 0);
    check("rst2_mem_addr", 32'(mem_addr), 0);
    check("rst2_f_instr", 32'(f_instr), 0);
    check("rst2_mem60", 32'(mem[8'h60]), 32'h98);
    check("rst2_mem61", 32'(mem[8'h61]), 32'h77);
    @(negedge clk);
    ld_req = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst2_idle", 32'(busy), 0);
    do_fetch("rst2_f", 8'h00, 16'h34FE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Access controller between the byte-wide instruction memory (256 x 8, big-endian 16-bit instructions) and two requesters: the program loader and the CPU fetch stage.
- Splits every 16-bit access into two byte cycles and arbitrates the single memory port, giving the loader priority.
- Detects the HALT word on fetch and freezes fetching until the halt is released.

Parameters:
- ADDR_W, 8, byte address width; wrap is modulo 2^ADDR_W.
- HALT_WORD, 16'h0000, fetched instruction value that halts fetching.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_req  in  1  loader write request; level, held until ld_ack.
- ld_addr  in  ADDR_W  byte address of the high byte of the word to write.
- ld_data  in  16  word to write; [15:8] goes to ld_addr, [7:0] to ld_addr+1.
- ld_ack  out  1  one-cycle pulse when the write has completed.
- f_req  in  1  fetch request; level, held until f_valid.
- f_pc  in  ADDR_W  byte address of the instruction's high byte.
- f_valid  out  1  one-cycle pulse when f_instr holds a new instruction.
- f_instr  out  16  fetched instruction; holds its value between fetches.
- halted  out  1  high while fetching is frozen by HALT_WORD.
- halt_clr  in  1  releases the halt; sampled only in HALT.
- busy  out  1  high in WR_HI, WR_LO, RD_HI and RD_LO.
- mem_addr  out  ADDR_W  memory byte address.
- mem_we  out  1  memory byte write enable; memory writes on the clk edge.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte; combinational from mem_addr.

Behaviour:
- States: IDLE, WR_HI, WR_LO, RD_HI, RD_LO, HALT.
- Reset (asynchronous, any state): state=IDLE; ld_ack, f_valid, halted, busy = 0; f_instr = 16'h0000; mem_we=0; mem_addr=0; mem_wdata=0; latched address/data registers = 0.
- Reset during WR_LO leaves a half-written word (high byte only). This is accepted; the loader must reissue the write.
- IDLE arbitration on a clock edge:
  - ld_req=1 -> latch ld_addr/ld_data, go to WR_HI. ld_req wins over a simultaneous f_req.
  - else f_req=1 -> latch f_pc, go to RD_HI.
- Requests are ignored in the IDLE cycle in which ld_ack or f_valid is high, so a still-asserted request is not re-issued.
- WR_HI: mem_addr=A, mem_we=1, mem_wdata=D[15:8]; next state WR_LO.
- WR_LO: mem_addr=A+1 (8'hFF wraps to 8'h00), mem_we=1, mem_wdata=D[7:0]. Next state is IDLE, or HALT if the write was started from HALT. ld_ack=1 for exactly the following cycle.
- RD_HI: mem_addr=A, mem_we=0; capture mem_rdata into hi_byte at the edge; next state RD_LO.
- RD_LO: mem_addr=A+1 (wrapping), mem_we=0. At the edge: f_instr <= {hi_byte, mem_rdata}, f_valid=1 for the next cycle.
  - Fetched word == HALT_WORD -> halted <= 1 in that same cycle, next state HALT.
  - Otherwise next state IDLE.
- Latency:
  - f_req sampled at edge T -> RD_HI in cycle T+1, RD_LO in T+2, f_valid/f_instr in T+3.
  - Write: ld_ack in T+3.
- Back-to-back: a new request is accepted at the end of the cycle following ld_ack/f_valid, giving a 4-cycle throughput.
- HALT:
  - f_req is ignored; no f_valid is produced.
  - ld_req is still serviced (HALT -> WR_HI -> WR_LO -> HALT). halted stays 1 throughout.
  - halt_clr=1 with no ld_req -> halted <= 0, next state IDLE.
  - ld_req and halt_clr together: the write wins, and halt_clr must be reasserted afterwards.
- halt_clr outside HALT has no effect.
- Odd addresses are legal and are not realigned.
- Every cycle outside WR_HI/WR_LO: mem_we=0 and mem_wdata=0.
- mem_addr and mem_we must not glitch across states; they are decoded from registered state.

Test Plan:
- Reset, then f_req=1, f_pc=8'h00 with memory[0..1]=8'h21,8'hFE -> f_valid high exactly 3 cycles after the sampling edge; f_instr=16'h21FE; busy high 2 cycles.
- ld_req=1, ld_addr=8'h10, ld_data=16'hBEEF -> mem_we high 2 cycles: addr 8'h10 with data 8'hBE, then 8'h11 with 8'hEF; ld_ack 1-cycle pulse. A fetch from 8'h10 then returns 16'hBEEF.
- ld_req and f_req raised in the same cycle -> write done first (ld_ack), fetch completes 4 cycles later with the written value; no request is dropped or duplicated.
- Write at ld_addr=8'hFF with 16'h1234 -> 8'h12 at 8'hFF, 8'h34 at 8'h00. Fetch from f_pc=8'hFF returns 16'h1234.
- Fetch of 16'h0000 -> f_valid with f_instr=0 and halted=1. A held f_req produces no further f_valid for 10 cycles. A loader write still acks with halted=1. halt_clr -> halted=0, and the next fetch proceeds.
- Assert reset_n=0 in the middle of WR_LO -> mem_we, busy, ld_ack, f_valid, halted drop to 0 immediately (asynchronously). After release the state is IDLE and a new fetch works normally.
